// File: rtl/frame_update_scheduler.sv
// Frame update scheduler: per-slot shadow registers committed to the character
// position RAM during vertical blanking. Optional frame counter: FRAME_UPDATE_FRAME_CNT_EN.
module frame_update_scheduler #(
  parameter int DATA_W  = 12,
  parameter int NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vblank,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [1:0]                wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      commit_busy,
  output logic                      commit_done,
  output logic [15:0]               frame_cnt
);

  typedef enum logic [1:0] {IDLE, COMMIT, DONE} state_t;

  state_t              state;
  logic                vblank_d;
  logic [NUM_REQ-1:0]  pending;
  logic [DATA_W-1:0]   shadow [NUM_REQ];
  logic [1:0]          rr_ptr;

  logic                vb_rise;
  logic                found;
  logic [1:0]          sel;
  logic [1:0]          next_ptr;
  logic                issue;
  logic [NUM_REQ-1:0]  accept;
  int unsigned         idx;

  assign vb_rise = vblank & ~vblank_d;

  // First pending slot at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = 2'(idx);
      end
    end
  end

  assign next_ptr = (32'(sel) == NUM_REQ - 1) ? 2'd0 : sel + 2'd1;
  assign issue    = found & (((state == IDLE) & vb_rise) | ((state == COMMIT) & vblank));

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !(wr_en && (32'(wr_addr) == i));
      accept[i]    = req_valid[i] & req_ready[i];
    end
  end

  // A fresh accept wins over the clear so a newer value is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) shadow[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          shadow[i]  <= req_data[i*DATA_W +: DATA_W];
          pending[i] <= 1'b1;
        end else if (issue && (32'(sel) == i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      vblank_d    <= 1'b0;
      rr_ptr      <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      commit_busy <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      vblank_d    <= vblank;
      wr_en       <= 1'b0;
      commit_done <= 1'b0;
      if (issue) begin
        wr_en   <= 1'b1;
        wr_addr <= sel;
        wr_data <= shadow[sel];
        rr_ptr  <= next_ptr;
      end
      case (state)
        IDLE: begin
          if (vb_rise) begin
            state       <= COMMIT;
            commit_busy <= 1'b1;
          end
        end
        COMMIT: begin
          if (!vblank) begin
            state       <= IDLE;
            commit_busy <= 1'b0;
          end else if (!found) begin
            state       <= DONE;
            commit_busy <= 1'b0;
            commit_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FRAME_UPDATE_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               frame_cnt_q <= '0;
    else if (state == DONE)  frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler; expected RAM writes are queued
// when requests/vblank are driven and popped as the write port fires.
module tb_frame_update_scheduler;
  localparam int DATA_W  = 12;
  localparam int NUM_REQ = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      vblank;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_en;
  logic [1:0]                wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      commit_busy;
  logic                      commit_done;
  logic [15:0]               frame_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int n_wr        = 0;
  int n_done      = 0;
  int exp_frames  = 0;
  int w0, d0;
  logic [13:0] sb [$];
  logic [13:0] exp_wr;

  frame_update_scheduler #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .vblank      (vblank),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit_busy (commit_busy),
    .commit_done (commit_done),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int slot, input logic [DATA_W-1:0] d);
    req_valid[slot] = 1'b1;
    req_data[slot*DATA_W +: DATA_W] = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},   32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_busy"},    32'(commit_busy), 32'd0);
    check({tag, "_done"},    32'(commit_done), 32'd0);
    check({tag, "_fcnt"},    32'(frame_cnt), 32'd0);
    check({tag, "_ready"},   32'(req_ready), 32'hF);
  endtask

  task automatic check_fcnt(input string tag);
`ifdef FRAME_UPDATE_FRAME_CNT_EN
    check(tag, 32'(frame_cnt), 32'(exp_frames));
`else
    check(tag, 32'(frame_cnt), 32'd0);
`endif
  endtask

  // Write-port scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (commit_done === 1'b1) n_done++;
      if (wr_en === 1'b1) begin
        n_wr++;
        check("wr_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_wr = sb.pop_front();
          check("wr_port", 32'({wr_addr, wr_data}), 32'(exp_wr));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; vblank = 1'b0; req_valid = '0; req_data = '0;
    tick(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick(2);

    // Two slots committed in round-robin order.
    set_req(0, 12'h123); set_req(2, 12'h456);
    tick; req_valid = '0;
    sb.push_back({2'd0, 12'h123}); sb.push_back({2'd2, 12'h456});
    w0 = n_wr; d0 = n_done;
    vblank = 1'b1;
    tick;
    check("t1_wr_en0", 32'(wr_en), 32'd1);
    check("t1_addr0", 32'(wr_addr), 32'd0);
    check("t1_busy", 32'(commit_busy), 32'd1);
    check("t1_ready0", 32'(req_ready), 32'b1110);
    tick;
    check("t1_addr1", 32'(wr_addr), 32'd2);
    check("t1_ready1", 32'(req_ready), 32'b1011);
    tick;
    check("t1_done", 32'(commit_done), 32'd1);
    check("t1_wr_off", 32'(wr_en), 32'd0);
    tick;
    check("t1_done_pulse", 32'(commit_done), 32'd0);
    check("t1_busy_off", 32'(commit_busy), 32'd0);
    exp_frames++;
    vblank = 1'b0; tick(2);
    check("t1_nwr", 32'(n_wr - w0), 32'd2);
    check("t1_ndone", 32'(n_done - d0), 32'd1);

    // Latest value wins.
    set_req(1, 12'h010); tick;
    set_req(1, 12'h020); tick; req_valid = '0;
    sb.push_back({2'd1, 12'h020});
    w0 = n_wr; d0 = n_done;
    vblank = 1'b1; tick(5); vblank = 1'b0; tick(2);
    check("t2_nwr", 32'(n_wr - w0), 32'd1);
    check("t2_ndone", 32'(n_done - d0), 32'd1);
    exp_frames++;

    // Write slot 3 so the round-robin pointer wraps to 0.
    set_req(3, 12'h333); tick; req_valid = '0;
    sb.push_back({2'd3, 12'h333});
    vblank = 1'b1; tick(5); vblank = 1'b0; tick(2);
    exp_frames++;

    // All four pending, vblank drops after two writes.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 12'(12'hA00 + i));
    tick; req_valid = '0;
    sb.push_back({2'd0, 12'hA00}); sb.push_back({2'd1, 12'hA01});
    w0 = n_wr; d0 = n_done;
    vblank = 1'b1;
    tick; check("t3_addr0", 32'(wr_addr), 32'd0);
    tick; check("t3_addr1", 32'(wr_addr), 32'd1);
    vblank = 1'b0;
    tick;
    check("t3_abort_busy", 32'(commit_busy), 32'd0);
    check("t3_abort_wr", 32'(wr_en), 32'd0);
    tick(4);
    check("t3_abort_nwr", 32'(n_wr - w0), 32'd2);
    check("t3_abort_ndone", 32'(n_done - d0), 32'd0);
    sb.push_back({2'd2, 12'hA02}); sb.push_back({2'd3, 12'hA03});
    vblank = 1'b1;
    tick; check("t3_resume_addr", 32'({wr_en, wr_addr}), 32'b110);
    tick(5); vblank = 1'b0; tick(2);
    check("t3_resume_nwr", 32'(n_wr - w0), 32'd4);
    check("t3_resume_ndone", 32'(n_done - d0), 32'd1);
    exp_frames++;

    // Empty commit.
    w0 = n_wr;
    vblank = 1'b1;
    tick;
    check("t4_busy", 32'(commit_busy), 32'd1);
    check("t4_wr_en", 32'(wr_en), 32'd0);
    tick; check("t4_done", 32'(commit_done), 32'd1);
    tick; check("t4_done_pulse", 32'(commit_done), 32'd0);
    exp_frames++;
    check_fcnt("t4_fcnt");
    vblank = 1'b0; tick(2);
    check("t4_nwr", 32'(n_wr - w0), 32'd0);

    // Request to a slot while it is on the write port is held off one cycle.
    set_req(3, 12'h3A3); tick; req_valid = '0;
    sb.push_back({2'd3, 12'h3A3});
    vblank = 1'b1;
    tick;
    check("t5_addr", 32'({wr_en, wr_addr}), 32'b111);
    set_req(3, 12'h7FF);
    #1 check("t5_ready_blocked", 32'(req_ready), 32'b0111);
    tick;
    check("t5_ready_back", 32'(req_ready), 32'hF);
    check("t5_done", 32'(commit_done), 32'd1);
    tick; req_valid = '0;
    exp_frames++;
    vblank = 1'b0; tick(2);
    sb.push_back({2'd3, 12'h7FF});
    w0 = n_wr;
    vblank = 1'b1;
    tick; check("t5_late_data", 32'(wr_data), 32'h7FF);
    tick(5); vblank = 1'b0; tick(2);
    check("t5_nwr", 32'(n_wr - w0), 32'd1);
    exp_frames++;
    check_fcnt("t5_fcnt");

    // Reset in the middle of a commit drops everything pending.
    set_req(0, 12'hB00); set_req(1, 12'hB01); set_req(2, 12'hB02);
    tick; req_valid = '0;
    vblank = 1'b1;
    tick;
    check("t6_in_commit", 32'(wr_en), 32'd1);
    reset = 1'b1; vblank = 1'b0;
    #1 check_reset_outputs("t6_rst");
    exp_frames = 0;
    tick(2);
    reset = 1'b0;
    tick(2);
    w0 = n_wr;
    vblank = 1'b1; tick(6); vblank = 1'b0; tick(2);
    check("t6_nwr", 32'(n_wr - w0), 32'd0);
    exp_frames++;
    check_fcnt("t6_fcnt");
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/frame_update_scheduler.md
FRAME_UPDATE_SCHEDULER -- requirements
Module: frame_update_scheduler

Interface
REQ-001 Parameter DATA_W, default 12, SHALL set the width of a position word (12 = {y[5:0],x[5:0]} packing used by the character position RAM).
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requester slots; the write address SHALL be 2 bits wide, so NUM_REQ <= 4.
REQ-003 clk  input  1  pixel clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 vblank  input  1  high while the raster is outside the active area (vertical blanking).
REQ-006 req_valid  input  NUM_REQ  per-slot update request.
REQ-007 req_data  input  NUM_REQ*DATA_W  packed per-slot position words; slot i uses bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  output  NUM_REQ  per-slot accept; a transfer occurs when req_valid[i] & req_ready[i].
REQ-009 wr_en  output  1  write strobe to the character position RAM.
REQ-010 wr_addr  output  2  RAM address, equal to the committed slot index.
REQ-011 wr_data  output  DATA_W  committed position word.
REQ-012 commit_busy  output  1  high while in COMMIT.
REQ-013 commit_done  output  1  one-cycle pulse when a frame commit completes.
REQ-014 frame_cnt  output  16  completed-commit counter (see Configuration).

Function
REQ-015 Each slot SHALL hold a DATA_W shadow register and a pending flag; an accepted transfer SHALL load the shadow register and set pending (latest value wins; no queueing).
REQ-016 req_ready[i] SHALL be 1 in every cycle except the cycle in which slot i is being driven on the write port.
REQ-017 FSM states: IDLE, COMMIT, DONE; IDLE->COMMIT when vblank=1 and its registered copy vblank_d=0 (rising edge).
REQ-018 On an edge detected in cycle N, COMMIT SHALL begin in cycle N+1 and wr_en SHALL be high in cycle N+1 if any slot is pending.
REQ-019 In COMMIT, one pending slot per cycle SHALL be written, chosen round-robin starting at rr_ptr; non-pending slots SHALL be skipped with no idle cycle; the written slot's pending flag SHALL clear in the same cycle.
REQ-020 After the write of the last pending slot, or immediately if none is pending at entry, the FSM SHALL go to DONE; DONE SHALL assert commit_done for exactly one cycle and then return to IDLE.
REQ-021 If vblank falls while in COMMIT, the FSM SHALL return to IDLE on the next cycle with no commit_done, uncommitted slots SHALL stay pending, and rr_ptr SHALL point to the first uncommitted slot.
REQ-022 After a completed commit rr_ptr SHALL advance to the slot after the last one written (wrapping NUM_REQ-1 -> 0).
REQ-023 wr_en, wr_addr, wr_data SHALL be registered outputs; wr_en SHALL be 0 outside COMMIT.
REQ-024 A slot not written in the current cycle SHALL accept requests during COMMIT; a newly pending slot ahead of the round-robin search SHALL be committed in the same vblank.
REQ-025 A vblank edge arriving while in DONE SHALL be ignored (vblank_d is already high).

Reset
REQ-026 While reset=1: FSM=IDLE, all pending flags=0, shadow registers=0, rr_ptr=0, vblank_d=0, wr_en=0, wr_addr=0, wr_data=0, commit_busy=0, commit_done=0, frame_cnt=0, req_ready=all ones.
REQ-027 Reset asserted mid-COMMIT SHALL discard all pending updates; no further write SHALL occur.

Configuration
REQ-028 With FRAME_UPDATE_FRAME_CNT_EN defined, frame_cnt SHALL increment (mod 2^16) in each DONE cycle; without it, frame_cnt SHALL be tied to 0 and no counter register SHALL be synthesized.

Verification
REQ-029 Slots 0,2 written 0x123,0x456 in active video, then vblank rises -> wr_en 2 cycles: (addr0,0x123),(addr2,0x456); commit_done 1 cycle later.
REQ-030 Slot 1 written 0x010 then 0x020 before vblank -> single write (addr1,0x020).
REQ-031 All 4 pending, vblank falls after 2 writes -> no commit_done; next vblank writes slots 2,3 first.
REQ-032 vblank rises with nothing pending -> no wr_en, commit_done pulse one cycle after COMMIT entry, frame_cnt +1 (macro defined) / stays 0 (undefined).
REQ-033 Slot 3 requests 0x7FF in the cycle slot 3 is written -> req_ready[3]=0 that cycle; held request accepted next cycle, committed on following vblank.
REQ-034 reset pulsed during COMMIT with 3 pending -> outputs at reset values; next vblank produces no writes.
